// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII helpers for the UART register-write command port.
package uart_cmd_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_IDX, P_EQ, P_HEX, P_END, P_ERR} parse_state_t;

    localparam logic [7:0] CH_W  = 8'h77;
    localparam logic [7:0] CH_WU = 8'h57;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;

    // Returns {valid, nibble}; letters share low bits, so both cases map via +9.
    function automatic logic [4:0] hex2nib(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return {1'b1, b[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-FF synchroniser, mid-bit sampling, one-cycle valid / framing-error pulses.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic [1:0]    sync_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rxs;

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Return to idle on the sample itself so a back-to-back start bit is caught.
                    if (cnt_q == DIV_M1) begin
                        cnt_q   <= '0;
                        valid_q <= rxs;
                        ferr_q  <= !rxs;
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid  = valid_q;
    assign rx_byte   = shift_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_reg_cmd_rx.sv
// UART debug port: parses "w<i>=<hhhh><CR|LF>" and issues a one-cycle register write.
module uart_reg_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115_200,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_rx,
    output logic          reg_we,
    output logic [AW-1:0] reg_waddr,
    output logic [15:0]   reg_wdata,
    output logic          cmd_err,
    output logic          rx_busy
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic [4:0] hex;

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (uart_rx),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    assign hex = hex2nib(rx_byte);

    parse_state_t  pst_q;
    logic [AW-1:0] idx_q;
    logic [15:0]   acc_q;
    logic [1:0]    nib_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [15:0]   wdata_q;
    logic          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst_q   <= P_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            nib_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            if (frame_err && pst_q != P_ERR) begin
                pst_q <= P_ERR;
                err_q <= 1'b1;
            end else if (rx_valid) begin
                case (pst_q)
                    P_IDLE: begin
                        if (rx_byte == CH_W || rx_byte == CH_WU) begin
                            pst_q <= P_IDX;
                        end else if (!is_eol(rx_byte)) begin
                            pst_q <= P_ERR;
                            err_q <= 1'b1;
                        end
                    end
                    P_IDX: begin
                        if (rx_byte >= CH_0 && rx_byte < CH_0 + 8'(NREGS)) begin
                            idx_q <= AW'(rx_byte - CH_0);
                            pst_q <= P_EQ;
                        end else begin
                            pst_q <= P_ERR;
                            err_q <= 1'b1;
                        end
                    end
                    P_EQ: begin
                        if (rx_byte == CH_EQ) begin
                            nib_q <= '0;
                            acc_q <= '0;
                            pst_q <= P_HEX;
                        end else begin
                            pst_q <= P_ERR;
                            err_q <= 1'b1;
                        end
                    end
                    P_HEX: begin
                        if (hex[4]) begin
                            acc_q <= {acc_q[11:0], hex[3:0]};
                            nib_q <= nib_q + 1'b1;
                            if (nib_q == 2'd3) pst_q <= P_END;
                        end else begin
                            pst_q <= P_ERR;
                            err_q <= 1'b1;
                        end
                    end
                    P_END: begin
                        if (is_eol(rx_byte)) begin
                            we_q    <= 1'b1;
                            waddr_q <= idx_q;
                            wdata_q <= acc_q;
                            pst_q   <= P_IDLE;
                        end else begin
                            pst_q <= P_ERR;
                            err_q <= 1'b1;
                        end
                    end
                    P_ERR: begin
                        if (is_eol(rx_byte)) pst_q <= P_IDLE;
                    end
                    default: pst_q <= P_IDLE;
                endcase
            end
        end
    end

    assign reg_we    = we_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_reg_cmd_rx.sv
// Directed bench for uart_reg_cmd_rx with a write scoreboard and cmd_err pulse counting.
module tb_uart_reg_cmd_rx;

    localparam int CLK_HZ = 3_686_400;
    localparam int BAUD   = 115_200;
    localparam int DIV    = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic        cmd_err;
    logic        rx_busy;

    uart_reg_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NREGS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .cmd_err   (cmd_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests   = 0;
    int  fails   = 0;
    int  err_cnt = 0;
    int  exp_err = 0;

    always @(negedge clk) begin : mon
        wr_t e;
        if (cmd_err === 1'b1) err_cnt++;
        if (reg_we === 1'b1) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: got addr=%0d data=%h, required no write", reg_waddr, reg_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                assert ({reg_waddr, reg_wdata} === {e.addr, e.data}) else begin
                    fails++;
                    $error("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                           reg_waddr, reg_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s.getc(i), 1'b1);
    endtask

    task automatic settle();
        repeat (4 * DIV) @(negedge clk);
    endtask

    initial begin
        logic seen;

        // reset state
        repeat (5) @(negedge clk);
        chk("rst_we", reg_we, 0);
        chk("rst_waddr", reg_waddr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", rx_busy, 0);

        // basic write
        expect_wr(3'd3, 16'h12AB);
        send_str("w3=12AB\r");
        settle();
        chk("t1_pending", exp_q.size(), 0);
        chk("t1_err", err_cnt, exp_err);
        chk("t1_hold_addr", reg_waddr, 3);
        chk("t1_hold_data", reg_wdata, 16'h12AB);

        // uppercase W, lowercase hex, CRLF
        expect_wr(3'd7, 16'hBEEF);
        send_str("W7=beef\r\n");
        settle();
        chk("t2_pending", exp_q.size(), 0);
        chk("t2_err", err_cnt, exp_err);

        // index out of range, then recovery
        send_str("w8=0000\r");
        settle();
        exp_err++;
        chk("t3_err", err_cnt, exp_err);
        chk("t3_hold_addr", reg_waddr, 7);
        expect_wr(3'd0, 16'h0001);
        send_str("w0=0001\r");
        settle();
        chk("t3_pending", exp_q.size(), 0);
        chk("t3_err2", err_cnt, exp_err);

        // bad hex digit, then framing error mid-hex, then recovery
        send_str("w2=1G34\r");
        settle();
        exp_err++;
        chk("t4_badhex_err", err_cnt, exp_err);
        send_str("w2=12");
        send_byte(8'h33, 1'b0);
        repeat (3 * DIV) @(negedge clk);
        exp_err++;
        chk("t4_frame_err", err_cnt, exp_err);
        send_str("\r");
        expect_wr(3'd2, 16'h5555);
        send_str("w2=5555\r");
        settle();
        chk("t4_pending", exp_q.size(), 0);
        chk("t4_err", err_cnt, exp_err);

        // short low glitch: false start only
        seen = 1'b0;
        uart_rx = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (i == 12) uart_rx = 1'b1;
            if (rx_busy === 1'b1) seen = 1'b1;
        end
        chk("t5_busy_seen", seen, 1);
        chk("t5_busy_clear", rx_busy, 0);
        chk("t5_glitch_err", err_cnt, exp_err);

        // back-to-back frames, two commands with no idle gap
        expect_wr(3'd4, 16'hA5C3);
        expect_wr(3'd5, 16'h0123);
        send_str("w4=a5C3\rw5=0123\n");
        settle();
        chk("t5_pending", exp_q.size(), 0);
        chk("t5_err", err_cnt, exp_err);

        // reset in the middle of a frame and of a command
        send_str("w1=AB");
        uart_rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        chk("t6_busy_pre", rx_busy, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_we", reg_we, 0);
        chk("t6_rst_waddr", reg_waddr, 0);
        chk("t6_rst_wdata", reg_wdata, 0);
        chk("t6_rst_err", cmd_err, 0);
        chk("t6_rst_busy", rx_busy, 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("t6_post_busy", rx_busy, 0);
        chk("t6_post_err", err_cnt, exp_err);
        expect_wr(3'd1, 16'h0F0F);
        send_str("w1=0F0F\r");
        settle();
        chk("t6_pending", exp_q.size(), 0);
        chk("t6_err", err_cnt, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
